// File: rtl/flash_cmd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : flash_cmd_seq                                                |
// | Description : Turns read/program/erase requests into StrataFlash bus-cycle |
// |               sequences on the single-byte controller handshake.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module flash_cmd_seq #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int POLL_MAX = 1000
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] fc_addr,
  output logic [DATA_W-1:0] fc_wdata,
  input  logic [DATA_W-1:0] fc_rdata,
  output logic              fc_dir,
  output logic              fc_do,
  input  logic              fc_done
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);

  localparam logic [1:0] C_OP_READ  = 2'b00;
  localparam logic [1:0] C_OP_PROG  = 2'b01;
  localparam logic [1:0] C_OP_ERASE = 2'b10;

  localparam logic [1:0] C_ERR_OK  = 2'b00;
  localparam logic [1:0] C_ERR_DEV = 2'b01;
  localparam logic [1:0] C_ERR_TMO = 2'b10;
  localparam logic [1:0] C_ERR_ILL = 2'b11;

  localparam logic [DATA_W-1:0] C_CMD_RD_ARR  = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] C_CMD_PROG    = DATA_W'(8'h40);
  localparam logic [DATA_W-1:0] C_CMD_ERASE   = DATA_W'(8'h20);
  localparam logic [DATA_W-1:0] C_CMD_CONFIRM = DATA_W'(8'hD0);
  localparam logic [DATA_W-1:0] C_CMD_RD_SR   = DATA_W'(8'h70);
  localparam logic [DATA_W-1:0] C_CMD_CLR_SR  = DATA_W'(8'h50);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_ARR  = 4'd1,
    S_RD_DATA = 4'd2,
    S_CMD1    = 4'd3,
    S_CMD2    = 4'd4,
    S_SR_CMD  = 4'd5,
    S_SR_POLL = 4'd6,
    S_CLR_SR  = 4'd7,
    S_RET_ARR = 4'd8,
    S_RESP    = 4'd9
  } state_t;

  state_t              r_state, w_state;
  logic                r_wait, w_wait;
  logic [1:0]          r_op, w_op;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [CNT_W-1:0]    r_poll, w_poll;
  logic                r_cmd_ready, w_cmd_ready;
  logic                r_rsp_valid, w_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata;
  logic [1:0]          r_rsp_err, w_rsp_err;
  logic [ADDR_W-1:0]   r_fc_addr, w_fc_addr;
  logic [DATA_W-1:0]   r_fc_wdata, w_fc_wdata;
  logic                r_fc_dir, w_fc_dir;
  logic                r_fc_do, w_fc_do;

  logic                w_bus_en;
  logic                w_bus_dir;
  logic [DATA_W-1:0]   w_bus_data;
  logic                w_xfer_done;
  logic [CNT_W-1:0]    w_poll_inc;
  logic                w_sr_err;

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign fc_addr   = r_fc_addr;
  assign fc_wdata  = r_fc_wdata;
  assign fc_dir    = r_fc_dir;
  assign fc_do     = r_fc_do;

  // Every state other than IDLE/RESP performs exactly one bus cycle.
  assign w_bus_en    = (r_state != S_IDLE) && (r_state != S_RESP);
  assign w_xfer_done = w_bus_en && r_wait && fc_done;
  assign w_poll_inc  = r_poll + CNT_W'(1);
  assign w_sr_err    = ((r_op == C_OP_ERASE) ? fc_rdata[5] : fc_rdata[4]) | fc_rdata[3] | fc_rdata[1];

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait      <= 1'b0;
      r_op        <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_poll      <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= C_ERR_OK;
      r_fc_addr   <= '0;
      r_fc_wdata  <= '0;
      r_fc_dir    <= 1'b1;
      r_fc_do     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_wait      <= w_wait;
      r_op        <= w_op;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_poll      <= w_poll;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_fc_addr   <= w_fc_addr;
      r_fc_wdata  <= w_fc_wdata;
      r_fc_dir    <= w_fc_dir;
      r_fc_do     <= w_fc_do;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_wait      = r_wait;
    w_op        = r_op;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_poll      = r_poll;
    w_cmd_ready = r_cmd_ready;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
    w_fc_addr   = r_fc_addr;
    w_fc_wdata  = r_fc_wdata;
    w_fc_dir    = r_fc_dir;
    w_fc_do     = 1'b0;
    w_bus_dir   = 1'b0;
    w_bus_data  = '0;

    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (r_cmd_ready && cmd_valid) begin
          w_cmd_ready = 1'b0;
          w_op        = cmd_op;
          w_addr      = cmd_addr;
          w_wdata     = cmd_wdata;
          w_poll      = '0;
          w_wait      = 1'b0;
          w_rsp_rdata = '0;
          w_rsp_err   = C_ERR_OK;
          case (cmd_op)
            C_OP_READ:             w_state = S_RD_ARR;
            C_OP_PROG, C_OP_ERASE: w_state = S_CMD1;
            default: begin
              w_rsp_err = C_ERR_ILL;
              w_state   = S_RESP;
            end
          endcase
        end
      end
      S_RD_ARR: begin
        w_bus_data = C_CMD_RD_ARR;
        if (w_xfer_done) w_state = S_RD_DATA;
      end
      S_RD_DATA: begin
        w_bus_dir = 1'b1;
        if (w_xfer_done) begin
          w_rsp_rdata = fc_rdata;
          w_state     = S_RESP;
        end
      end
      S_CMD1: begin
        w_bus_data = (r_op == C_OP_PROG) ? C_CMD_PROG : C_CMD_ERASE;
        if (w_xfer_done) w_state = S_CMD2;
      end
      S_CMD2: begin
        w_bus_data = (r_op == C_OP_PROG) ? r_wdata : C_CMD_CONFIRM;
        if (w_xfer_done) w_state = S_SR_CMD;
      end
      S_SR_CMD: begin
        w_bus_data = C_CMD_RD_SR;
        if (w_xfer_done) w_state = S_SR_POLL;
      end
      S_SR_POLL: begin
        w_bus_dir = 1'b1;
        if (w_xfer_done) begin
          w_poll      = w_poll_inc;
          w_rsp_rdata = fc_rdata;
          if (fc_rdata[7]) begin
            w_rsp_err = w_sr_err ? C_ERR_DEV : C_ERR_OK;
            w_state   = w_sr_err ? S_CLR_SR : S_RET_ARR;
          end else if (w_poll_inc == CNT_W'(POLL_MAX)) begin
            w_rsp_err = C_ERR_TMO;
            w_state   = S_RET_ARR;
          end
        end
      end
      S_CLR_SR: begin
        w_bus_data = C_CMD_CLR_SR;
        if (w_xfer_done) w_state = S_RET_ARR;
      end
      S_RET_ARR: begin
        w_bus_data = C_CMD_RD_ARR;
        if (w_xfer_done) w_state = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        w_state     = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    // Shared bus-cycle handshake: launch once, then wait for completion.
    if (w_bus_en) begin
      if (!r_wait) begin
        w_fc_do    = 1'b1;
        w_fc_addr  = r_addr;
        w_fc_wdata = w_bus_data;
        w_fc_dir   = w_bus_dir;
        w_wait     = 1'b1;
      end else if (fc_done) begin
        w_wait = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_cmd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_flash_cmd_seq                                             |
// | Description : Self-checking bench for flash_cmd_seq with a fake controller.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_flash_cmd_seq;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int POLL_MAX = 4;
  localparam int LAT      = 3;

  logic              CLK = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;
  logic [ADDR_W-1:0] fc_addr;
  logic [DATA_W-1:0] fc_wdata;
  logic [DATA_W-1:0] fc_rdata;
  logic              fc_dir;
  logic              fc_do;
  logic              fc_done;

  flash_cmd_seq #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .POLL_MAX (POLL_MAX)
  ) u_dut (
    .CLK       (CLK),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .fc_addr   (fc_addr),
    .fc_wdata  (fc_wdata),
    .fc_rdata  (fc_rdata),
    .fc_dir    (fc_dir),
    .fc_do     (fc_do),
    .fc_done   (fc_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       dir;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_t;

  typedef struct {
    logic [7:0] rdata;
    logic [1:0] err;
  } rsp_t;

  bus_t       exp_bus[$];
  rsp_t       exp_rsp[$];
  logic [7:0] plan[$];
  logic [7:0] dev_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         n_do     = 0;
  int         n_rsp    = 0;
  logic [7:0] last_rdata;
  logic [1:0] last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic dir, input logic [7:0] a, input logic [7:0] d);
    bus_t b;
    b.dir  = dir;
    b.addr = a;
    b.data = d;
    exp_bus.push_back(b);
  endtask

  // Request-level model: the bus script and response implied by op and the device plan.
  task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    rsp_t       r;
    logic [7:0] sr;
    bit         stop;
    r.rdata = 8'h00;
    r.err   = 2'b00;
    stop    = 1'b0;
    case (op)
      2'b00: begin
        push_bus(1'b0, a, 8'hFF);
        push_bus(1'b1, a, 8'h00);
        r.rdata = (plan.size() > 0) ? plan[0] : 8'h00;
      end
      2'b11: r.err = 2'b11;
      default: begin
        push_bus(1'b0, a, (op == 2'b01) ? 8'h40 : 8'h20);
        push_bus(1'b0, a, (op == 2'b01) ? d : 8'hD0);
        push_bus(1'b0, a, 8'h70);
        r.err = 2'b10;
        for (int i = 0; i < POLL_MAX && !stop; i++) begin
          sr = (i < plan.size()) ? plan[i] : 8'h00;
          push_bus(1'b1, a, 8'h00);
          r.rdata = sr;
          if (sr[7]) begin
            stop = 1'b1;
            if (op == 2'b01) r.err = (sr[4] || sr[3] || sr[1]) ? 2'b01 : 2'b00;
            else             r.err = (sr[5] || sr[3] || sr[1]) ? 2'b01 : 2'b00;
          end
        end
        if (r.err == 2'b01) push_bus(1'b0, a, 8'h50);
        push_bus(1'b0, a, 8'hFF);
      end
    endcase
    exp_rsp.push_back(r);
  endtask

  // Fake controller: completes each bus cycle LAT cycles after fc_do; it has no reset.
  initial begin
    int   pend;
    logic pend_dir;
    pend     = 0;
    pend_dir = 1'b0;
    fc_done  = 1'b0;
    fc_rdata = 8'h5A;
    forever begin
      @(posedge CLK);
      #1;
      fc_done  = 1'b0;
      fc_rdata = 8'h5A;
      if (fc_do) begin
        pend     = LAT;
        pend_dir = fc_dir;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fc_done = 1'b1;
          if (pend_dir) fc_rdata = (dev_q.size() > 0) ? dev_q.pop_front() : 8'h00;
        end
      end
    end
  end

  // Per-cycle comparison against the model's bus script and responses.
  initial begin
    logic       outst;
    logic       prev_rv;
    logic [7:0] o_addr;
    logic [7:0] o_data;
    logic       o_dir;
    bus_t       e;
    rsp_t       r;
    outst   = 1'b0;
    prev_rv = 1'b0;
    o_addr  = 8'h00;
    o_data  = 8'h00;
    o_dir   = 1'b0;
    forever begin
      @(negedge CLK);
      if (rst) begin
        outst   = 1'b0;
        prev_rv = 1'b0;
      end else begin
        if (fc_do) begin
          n_do++;
          chk("single_outstanding", outst, 1'b0);
          chk("fc_do_expected", exp_bus.size() > 0, 1'b1);
          if (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            chk("fc_dir", fc_dir, e.dir);
            chk("fc_addr", fc_addr, e.addr);
            if (!e.dir) chk("fc_wdata", fc_wdata, e.data);
          end
          outst  = 1'b1;
          o_addr = fc_addr;
          o_data = fc_wdata;
          o_dir  = fc_dir;
        end else if (outst) begin
          chk("hold_addr", fc_addr, o_addr);
          chk("hold_dir", fc_dir, o_dir);
          chk("hold_wdata", fc_wdata, o_data);
        end
        if (fc_done) outst = 1'b0;
        if (rsp_valid) begin
          n_rsp++;
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
          chk("rsp_single_cycle", prev_rv, 1'b0);
          chk("ready_low_in_rsp", cmd_ready, 1'b0);
          chk("bus_done_before_rsp", exp_bus.size(), 0);
          chk("rsp_expected", exp_rsp.size() > 0, 1'b1);
          if (exp_rsp.size() > 0) begin
            r = exp_rsp.pop_front();
            chk("rsp_rdata", rsp_rdata, r.rdata);
            chk("rsp_err", rsp_err, r.err);
          end
        end
        prev_rv = rsp_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
    chk({tag, "_rsp_err"}, rsp_err, 2'b00);
    chk({tag, "_fc_do"}, fc_do, 1'b0);
    chk({tag, "_fc_dir"}, fc_dir, 1'b1);
    chk({tag, "_fc_addr"}, fc_addr, 8'h00);
    chk({tag, "_fc_wdata"}, fc_wdata, 8'h00);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                       output int pulses);
    int n;
    int r0;
    int d0;
    dev_q = plan;
    model(op, a, d);
    wait_ready();
    r0        = n_rsp;
    d0        = n_do;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (n_rsp == r0 && n < 300) begin
      tick();
      n++;
    end
    chk("rsp_arrived", n_rsp != r0, 1'b1);
    pulses = n_do - d0;
  endtask

  initial begin
    int p;
    int d0;
    int r0;
    int n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_vals("por");
    rst = 1'b0;
    tick();

    plan = '{8'hC9};
    issue(2'b00, 8'h35, 8'h00, p);
    chk("read_pulses", p, 2);
    chk("read_rdata_lit", last_rdata, 8'hC9);
    chk("read_err_lit", last_err, 2'b00);

    plan = '{8'h00, 8'h00, 8'h80};
    issue(2'b01, 8'h35, 8'hC9, p);
    chk("prog_pulses", p, 7);
    chk("prog_rdata_lit", last_rdata, 8'h80);
    chk("prog_err_lit", last_err, 2'b00);

    plan = '{8'hA0};
    issue(2'b10, 8'h10, 8'h00, p);
    chk("erase_pulses", p, 6);
    chk("erase_rdata_lit", last_rdata, 8'hA0);
    chk("erase_err_lit", last_err, 2'b01);

    plan = '{};
    issue(2'b01, 8'h22, 8'h5A, p);
    chk("tmo_pulses", p, 8);
    chk("tmo_rdata_lit", last_rdata, 8'h00);
    chk("tmo_err_lit", last_err, 2'b10);

    // Abort a program during status polling; the first poll's completion arrives after reset.
    plan  = '{};
    dev_q = plan;
    model(2'b01, 8'h44, 8'h77);
    wait_ready();
    d0        = n_do;
    r0        = n_rsp;
    cmd_op    = 2'b01;
    cmd_addr  = 8'h44;
    cmd_wdata = 8'h77;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (n_do < d0 + 4 && n < 100) begin
      tick();
      n++;
    end
    chk("abort_reached_poll", n_do, d0 + 4);
    rst = 1'b1;
    exp_bus.delete();
    exp_rsp.delete();
    #1;
    check_reset_vals("abort");
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("abort_no_rsp", n_rsp, r0);
    chk("abort_no_bus", n_do, d0 + 4);
    chk("abort_idle_ready", cmd_ready, 1'b1);
    plan = '{8'h3C};
    issue(2'b00, 8'h44, 8'h00, p);
    chk("post_abort_pulses", p, 2);
    chk("post_abort_rdata_lit", last_rdata, 8'h3C);
    chk("post_abort_err_lit", last_err, 2'b00);

    // Illegal op with cmd_valid held high: two back-to-back accepts.
    plan = '{};
    model(2'b11, 8'h99, 8'h00);
    model(2'b11, 8'h99, 8'h00);
    wait_ready();
    d0        = n_do;
    r0        = n_rsp;
    cmd_op    = 2'b11;
    cmd_addr  = 8'h99;
    cmd_valid = 1'b1;
    tick();
    chk("ill_c0_ready", cmd_ready, 1'b0);
    chk("ill_c0_rsp_valid", rsp_valid, 1'b0);
    tick();
    chk("ill_c1_rsp_valid", rsp_valid, 1'b1);
    chk("ill_c1_ready", cmd_ready, 1'b0);
    chk("ill_c1_err_lit", rsp_err, 2'b11);
    chk("ill_c1_rdata_lit", rsp_rdata, 8'h00);
    tick();
    chk("ill_c2_ready", cmd_ready, 1'b1);
    chk("ill_c2_rsp_valid", rsp_valid, 1'b0);
    tick();
    chk("ill_c3_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    tick();
    chk("ill_c4_rsp_valid", rsp_valid, 1'b1);
    tick();
    chk("ill_pulses", n_do - d0, 0);
    chk("ill_rsp_count", n_rsp - r0, 2);

    repeat (3) tick();
    chk("bus_script_drained", exp_bus.size(), 0);
    chk("rsp_script_drained", exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
